branch_predictor: RTL
=====================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port reset_n  input  1  reset; synchronous, active-low.
REQ-003 SHALL have port pc_IF  input  16  address of the instruction being fetched this cycle.
REQ-004 SHALL have port branch_predicted_pc_IF  output  16  next fetch address, forwarded into the IF/ID latch.
REQ-005 SHALL have port predict_hit_IF  output  1  1 = valid tag match for pc_IF.
REQ-006 SHALL have port predict_taken_IF  output  1  1 = branch_predicted_pc_IF is the stored target.
REQ-007 SHALL have port update_en  input  1  single-cycle strobe from EX when a control-flow instruction resolves.
REQ-008 SHALL have port update_pc  input  16  PC of the resolving instruction.
REQ-009 SHALL have port update_taken  input  1  actual outcome of the resolving instruction.
REQ-010 SHALL have port update_target  input  16  actual target of the resolving instruction.

Function
REQ-011 SHALL hold 16 BTB entries; each entry is valid (1 b), tag (12 b), target (16 b) and ctr (2 b); index = pc[3:0], tag = pc[15:4].
REQ-012 SHALL compute the lookup combinationally from pc_IF in the same cycle: hit = valid[idx] && tag[idx] == pc_IF[15:4].
REQ-013 SHALL drive predict_taken_IF = hit && ctr[idx][1].
REQ-014 SHALL drive branch_predicted_pc_IF = target[idx] when predict_taken_IF = 1; otherwise pc_IF + 1, truncated to 16 bits (16'hFFFF -> 16'h0000).
REQ-015 SHALL apply updates only at the rising edge with update_en = 1; with update_en = 0, table state SHALL NOT change.
REQ-016 SHALL, on an update hit with update_taken = 1, increment ctr with saturation at 2'b11 and write update_target into target.
REQ-017 SHALL, on an update hit with update_taken = 0, decrement ctr with saturation at 2'b00 and leave target unchanged.
REQ-018 SHALL, on an update miss with update_taken = 1, allocate the entry: valid = 1, tag = update_pc[15:4], target = update_target, ctr = 2'b10. Any previous occupant of the index is overwritten.
REQ-019 SHALL NOT allocate on an update miss with update_taken = 0.
REQ-020 SHALL evaluate a lookup and an update to the same index in the same cycle against the pre-update state; the update becomes visible to lookups from the next cycle.
REQ-021 SHALL be independent of pipeline stall and flush: lookups are purely combinational and updates are gated only by update_en.

Reset
REQ-022 SHALL, on a clk edge with reset_n = 0, clear every valid bit and set every ctr to 2'b01; tag and target contents are don't-care.
REQ-023 SHALL give reset priority over a simultaneous update_en.
REQ-024 SHALL, during reset and after it, drive predict_hit_IF = 0, predict_taken_IF = 0 and branch_predicted_pc_IF = pc_IF + 1 until the first allocation.

Configuration
REQ-025 SHALL, with macro BTB_2BIT_COUNTER_EN defined, implement the 2-bit saturating counter behaviour of REQ-013, REQ-016 and REQ-017.
REQ-026 SHALL, with BTB_2BIT_COUNTER_EN undefined:
- omit the ctr storage;
- drive predict_taken_IF = hit;
- on an update hit with update_taken = 0, clear the entry's valid bit;
- on an update hit with update_taken = 1, rewrite the entry's target.
All other behaviour is unchanged.

Verification
REQ-027 SHALL cover reset then lookup: pc_IF = 16'h0040 -> predict_hit_IF = 0, branch_predicted_pc_IF = 16'h0041; pc_IF = 16'hFFFF -> 16'h0000.
REQ-028 SHALL cover allocate: update pc 16'h0013, taken, target 16'h0080; next cycle pc_IF = 16'h0013 -> hit = 1, taken = 1, predicted pc = 16'h0080; pc_IF = 16'h0023 (same index, different tag) -> hit = 0, predicted pc = 16'h0024.
REQ-029 SHALL cover hysteresis (macro defined): after REQ-028, one not-taken update -> ctr = 01, prediction 16'h0014; two taken updates -> ctr = 11; one not-taken update -> ctr = 10, still predicts 16'h0080.
REQ-030 SHALL cover same-cycle lookup/update: pc_IF = update_pc = 16'h0005 on a miss, taken -> that cycle predicts 16'h0006; the following cycle predicts update_target.
REQ-031 SHALL cover conflict and no-allocate: update pc 16'h0105 not-taken on a miss -> no entry created; update pc 16'h0105 taken, target 16'h0200 -> replaces the 16'h0005 entry, and lookup of 16'h0005 misses.
REQ-032 SHALL cover reset mid-operation: reset_n = 0 for one edge with update_en = 1 -> all lookups miss afterwards; with the macro undefined, one not-taken hit update invalidates the entry.

Source files
------------

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
//
// 16-entry direct-mapped branch target buffer for the IF stage.
//
// The lookup is purely combinational on pc_IF. Training happens on the rising
// edge of clk whenever update_en is high, using the resolved outcome from EX.
// Each entry holds a valid bit, a 12-bit tag and a 16-bit target, and
// optionally a 2-bit saturating direction counter.
// index = pc[3:0], tag = pc[15:4].
//
// Optional feature macro: BTB_2BIT_COUNTER_EN
//   defined   : each entry carries a 2-bit saturating counter. The entry
//               predicts taken when ctr[1] is set. Taken hits increment the
//               counter and refresh the target. Not-taken hits decrement it.
//   undefined : there is no counter. A hit always predicts taken. A not-taken
//               hit invalidates the entry, and a taken hit rewrites the target.
//
// Ports
//   clk                    in   rising-edge clock for all state
//   reset_n                in   synchronous, active-low reset
//   pc_IF[15:0]            in   fetch address this cycle
//   branch_predicted_pc_IF out  next fetch address (stored target or pc_IF+1)
//   predict_hit_IF         out  valid tag match for pc_IF
//   predict_taken_IF       out  branch_predicted_pc_IF is the stored target
//   update_en              in   one-cycle strobe when a branch resolves in EX
//   update_pc[15:0]        in   PC of the resolving instruction
//   update_taken           in   actual outcome
//   update_target[15:0]    in   actual target
// -----------------------------------------------------------------------------
module branch_predictor (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] pc_IF,
    output logic [15:0] branch_predicted_pc_IF,
    output logic        predict_hit_IF,
    output logic        predict_taken_IF,
    input  logic        update_en,
    input  logic [15:0] update_pc,
    input  logic        update_taken,
    input  logic [15:0] update_target
);

    localparam int ENTRIES = 16;
    localparam int IDX_W   = 4;
    localparam int TAG_W   = 16 - IDX_W;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [IDX_W-1:0] idx;
    } pc_split_t;

    // ---------------------------------------------------------------- storage
    // Tag and target are not reset. A cleared valid bit masks them.
    logic [ENTRIES-1:0]             valid_q;
    logic [ENTRIES-1:0][TAG_W-1:0]  tag_q;
    logic [ENTRIES-1:0][15:0]       target_q;
`ifdef BTB_2BIT_COUNTER_EN
    logic [ENTRIES-1:0][1:0]        ctr_q;

    function automatic logic [1:0] sat_inc(input logic [1:0] c);
        return (c == 2'b11) ? 2'b11 : c + 2'd1;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] c);
        return (c == 2'b00) ? 2'b00 : c - 2'd1;
    endfunction
`endif

    // ----------------------------------------------------------------- lookup
    pc_split_t lk;
    logic      lk_hit;
    logic      lk_taken;

    assign lk = pc_split_t'(pc_IF);

    always_comb begin
        lk_hit   = valid_q[lk.idx] && (tag_q[lk.idx] == lk.tag);
`ifdef BTB_2BIT_COUNTER_EN
        lk_taken = lk_hit && ctr_q[lk.idx][1];
`else
        lk_taken = lk_hit;
`endif
    end

    assign predict_hit_IF         = lk_hit;
    assign predict_taken_IF       = lk_taken;
    // The +1 wraps naturally at 16 bits (FFFF -> 0000).
    assign branch_predicted_pc_IF = lk_taken ? target_q[lk.idx] : (pc_IF + 16'd1);

    // ----------------------------------------------------------------- update
    // The hit check reads the registered state. A lookup and an update to the
    // same index in one cycle therefore both see the pre-update entry.
    pc_split_t up;
    logic      up_hit;

    assign up     = pc_split_t'(update_pc);
    assign up_hit = valid_q[up.idx] && (tag_q[up.idx] == up.tag);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            // Reset takes priority over any update in the same cycle.
            valid_q <= '0;
`ifdef BTB_2BIT_COUNTER_EN
            ctr_q   <= {ENTRIES{2'b01}};
`endif
        end else if (update_en) begin
            if (up_hit) begin
`ifdef BTB_2BIT_COUNTER_EN
                if (update_taken) begin
                    ctr_q[up.idx]    <= sat_inc(ctr_q[up.idx]);
                    target_q[up.idx] <= update_target;
                end else begin
                    ctr_q[up.idx]    <= sat_dec(ctr_q[up.idx]);
                end
`else
                if (update_taken) begin
                    target_q[up.idx] <= update_target;
                end else begin
                    valid_q[up.idx]  <= 1'b0;
                end
`endif
            end else if (update_taken) begin
                // Allocate. Any entry already at this index is evicted.
                valid_q[up.idx]  <= 1'b1;
                tag_q[up.idx]    <= up.tag;
                target_q[up.idx] <= update_target;
`ifdef BTB_2BIT_COUNTER_EN
                ctr_q[up.idx]    <= 2'b10;
`endif
            end
            // A not-taken miss does not allocate.
        end
    end

endmodule
